mesh_port_arbiter: RTL and testbench



---
 rtl/mesh_port_arbiter_pkg.sv | 36 +++
 rtl/mesh_port_arbiter_if.sv | 28 ++
 rtl/mesh_port_arbiter_rr_pick.sv | 26 ++
 rtl/mesh_port_arbiter.sv | 83 ++++++++
 tb/tb_mesh_port_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mesh_port_arbiter_pkg.sv
// mesh_arb_pkg: shared FSM state, packet layout and sizing helpers for the mesh port arbiters.
package mesh_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, XFER} arb_state_e;

  localparam int PCKG_SZ   = 40;
  localparam int NXT_W     = 8;
  localparam int ROW_W     = 4;
  localparam int COL_W     = 4;
  localparam int MODE_W    = 1;
  localparam int PAYLOAD_W = PCKG_SZ - NXT_W - ROW_W - COL_W - MODE_W;
  localparam int NXT_LSB   = PCKG_SZ - NXT_W;
  localparam int ROW_LSB   = NXT_LSB - ROW_W;
  localparam int COL_LSB   = ROW_LSB - COL_W;
  localparam int MODE_LSB  = COL_LSB - MODE_W;
  localparam int PAYLOAD_LSB = 0;

  localparam logic [NXT_W-1:0] BROADCAST = {NXT_W{1'b1}};

  typedef struct packed {
    logic [NXT_W-1:0]     nxt_jump;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic [MODE_W-1:0]    mode;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_t;

  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction

  function automatic logic is_broadcast(input pkt_t p);
    return p.nxt_jump == BROADCAST;
  endfunction

endpackage

// File: rtl/mesh_port_arbiter_if.sv
// mesh_port_arbiter_if: requester-side and downstream-side signals of one router output port.
interface mesh_port_arbiter_if import mesh_arb_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int pckg_sz = 40,
  parameter int GW      = idx_w(N_REQ)
);
  logic [N_REQ-1:0]         pndng;
  logic [N_REQ-1:0]         route_ok;
  logic [N_REQ*pckg_sz-1:0] data_in;
  logic                     full;
  logic [N_REQ-1:0]         pop;
  logic                     push;
  logic [pckg_sz-1:0]       data_out;
  logic [GW-1:0]            grant_id;
  logic                     busy;
  logic                     stall_err;
  logic [15:0]              pkt_cnt;

  modport master (
    input  pndng, route_ok, data_in, full,
    output pop, push, data_out, grant_id, busy, stall_err, pkt_cnt
  );

  modport slave (
    output pndng, route_ok, data_in, full,
    input  pop, push, data_out, grant_id, busy, stall_err, pkt_cnt
  );
endinterface

// File: rtl/mesh_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req scanning from ptr+1 upward modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  logic [W-1:0] cand;

  // Scanning farthest-first lets the nearest hit overwrite, so no found flag is needed.
  always_comb begin
    valid_o = 1'b0;
    idx_o = '0;
    cand = '0;
    for (int k = N; k >= 1; k--) begin
      cand = W'((int'(ptr_i) + k) % N);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o = cand;
      end
    end
  end
endmodule

// File: rtl/mesh_port_arbiter.sv
// mesh_port_arbiter: round-robin share of one router output port among N_REQ input FIFOs.
module mesh_port_arbiter import mesh_arb_pkg::*; #(
  parameter int N_REQ    = 4,
  parameter int pckg_sz  = 40,
  parameter int max_wait = 16
) (
  input logic              clk,
  input logic              reset,
  mesh_port_arbiter_if.master bus
);
  localparam int GW = idx_w(N_REQ);
  localparam int SW = $clog2(max_wait + 1);

  arb_state_e         state_q;
  logic [GW-1:0]      rr_ptr_q, grant_q, win;
  logic [pckg_sz-1:0] data_q, dout_q;
  logic [N_REQ-1:0]   req, pop_q;
  logic               push_q, stall_err_q, win_v;
  logic [SW-1:0]      stall_cnt_q, stall_cnt_d;
  logic [15:0]        pkt_cnt_q;

  assign req = bus.pndng & bus.route_ok;
  assign stall_cnt_d = (stall_cnt_q == SW'(max_wait)) ? stall_cnt_q : stall_cnt_q + 1'b1;

  rr_pick #(.N(N_REQ), .W(GW)) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .valid_o (win_v),
    .idx_o   (win)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= GW'(N_REQ - 1);
      grant_q     <= '0;
      data_q      <= '0;
      dout_q      <= '0;
      pop_q       <= '0;
      push_q      <= 1'b0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      push_q <= 1'b0;
      pop_q  <= '0;
      case (state_q)
        IDLE: if (win_v) begin
          grant_q <= win;
          data_q  <= bus.data_in[int'(win)*pckg_sz +: pckg_sz];
          state_q <= GRANT;
        end
        GRANT: if (!bus.pndng[grant_q]) begin
          stall_cnt_q <= '0;
          state_q     <= IDLE;
        end else if (bus.full) begin
          stall_cnt_q <= stall_cnt_d;
          if (stall_cnt_d == SW'(max_wait)) stall_err_q <= 1'b1;
        end else begin
          stall_cnt_q <= '0;
          push_q      <= 1'b1;
          pop_q       <= N_REQ'(1) << grant_q;
          dout_q      <= data_q;
          state_q     <= XFER;
        end
        XFER: begin
          rr_ptr_q  <= grant_q;
          pkt_cnt_q <= pkt_cnt_q + 16'd1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pop       = pop_q;
  assign bus.push      = push_q;
  assign bus.data_out  = dout_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.stall_err = stall_err_q;
  assign bus.pkt_cnt   = pkt_cnt_q;
endmodule

// File: tb/tb_mesh_port_arbiter.sv
// tb_mesh_port_arbiter: vector table plus scoreboarded corner-case sequences for mesh_port_arbiter.
module tb_mesh_port_arbiter;
  localparam int N = 4;
  localparam int PW = 40;

  typedef struct {
    logic [1:0]  id;
    logic [PW-1:0] data;
  } exp_t;

  typedef struct {
    logic [N-1:0] pndng;
    logic [N-1:0] route;
    logic [1:0]   grant;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int n_push = 0;
  int target = 0;
  int exp_cnt = 0;
  int pop_cnt [N];
  exp_t q [$];
  exp_t e;
  vec_t vecs [8];

  mesh_port_arbiter_if #(.N_REQ(N), .pckg_sz(PW)) bus ();

  mesh_port_arbiter #(.N_REQ(N), .pckg_sz(PW), .max_wait(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] lane(input int i);
    return bus.data_in[i*PW +: PW];
  endfunction

  task automatic expect_pkt(input int id);
    q.push_back('{2'(id), lane(id)});
    target++;
  endtask

  task automatic wait_push();
    int t = 0;
    while (n_push < target && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("push_wait", 64'(n_push), 64'(target));
  endtask

  always @(negedge clk) begin
    if (bus.push) begin
      n_push++;
      for (int i = 0; i < N; i++) if (bus.pop[i]) pop_cnt[i]++;
      if (q.size() == 0) check("unexpected_push", 64'(bus.push), 64'd0);
      else begin
        e = q.pop_front();
        check("grant_id", 64'(bus.grant_id), 64'(e.id));
        check("data_out", 64'(bus.data_out), 64'(e.data));
        check("pop_onehot", 64'(bus.pop), 64'(4'b0001 << e.id));
      end
    end else check("pop_idle", 64'(bus.pop), 64'd0);
  end

  initial begin
    vecs[0] = '{4'b0010, 4'b1111, 2'd1};
    vecs[1] = '{4'b1111, 4'b1111, 2'd2};
    vecs[2] = '{4'b1111, 4'b1011, 2'd3};
    vecs[3] = '{4'b0110, 4'b1111, 2'd1};
    vecs[4] = '{4'b1111, 4'b0011, 2'd0};
    vecs[5] = '{4'b1001, 4'b1111, 2'd3};
    vecs[6] = '{4'b0001, 4'b0001, 2'd0};
    vecs[7] = '{4'b1101, 4'b1100, 2'd2};
    bus.pndng = '0;
    bus.route_ok = '1;
    bus.full = 1'b0;
    bus.data_in = '0;
    for (int i = 0; i < N; i++) pop_cnt[i] = 0;
    @(negedge clk);
    #1;
    check("rst_push", 64'(bus.push), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_data", 64'(bus.data_out), 64'd0);
    check("rst_grant", 64'(bus.grant_id), 64'd0);
    check("rst_stall", 64'(bus.stall_err), 64'd0);
    check("rst_cnt", 64'(bus.pkt_cnt), 64'd0);
    reset = 1'b0;

    // Single request with exact cycle timing.
    @(negedge clk);
    bus.data_in[1*PW +: PW] = 40'h12_3456_789A;
    bus.pndng = 4'b0010;
    expect_pkt(1);
    @(negedge clk);
    #1;
    check("t1_grant", 64'(bus.grant_id), 64'd1);
    check("t1_busy", 64'(bus.busy), 64'd1);
    check("t1_nopush", 64'(bus.push), 64'd0);
    @(negedge clk);
    #1;
    check("t1_push", 64'(bus.push), 64'd1);
    check("t1_pop", 64'(bus.pop), 64'b0010);
    bus.pndng = '0;
    @(negedge clk);
    #1;
    check("t1_cnt", 64'(bus.pkt_cnt), 64'd1);
    exp_cnt = 1;
    @(negedge clk);
    check("t1_rr_idle", 64'(bus.busy), 64'd0);

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) bus.data_in[i*PW +: PW] = {8'($urandom), 32'($urandom)};
      bus.route_ok = vecs[v].route;
      bus.pndng = vecs[v].pndng;
      expect_pkt(int'(vecs[v].grant));
      wait_push();
      bus.pndng = '0;
      exp_cnt++;
      @(negedge clk);
      #1;
      check("vec_cnt", 64'(bus.pkt_cnt), 64'(exp_cnt));
    end

    // Fairness from a fresh reset: rr_ptr=3 so order starts at 0.
    @(negedge clk);
    reset = 1'b1;
    bus.route_ok = '1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) pop_cnt[i] = 0;
    bus.pndng = 4'b1111;
    for (int k = 0; k < 12; k++) expect_pkt(k % 4);
    wait_push();
    bus.pndng = '0;
    @(negedge clk);
    #1;
    check("fair_cnt", 64'(bus.pkt_cnt), 64'd12);
    for (int i = 0; i < N; i++) check("fair_pops", 64'(pop_cnt[i]), 64'd3);

    // Backpressure; a head change while held must not alter the sent data.
    @(negedge clk);
    bus.full = 1'b1;
    bus.pndng = 4'b0100;
    expect_pkt(2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      check("bp_hold", 64'(bus.push), 64'd0);
      if (c == 0) bus.data_in[2*PW +: PW] = ~bus.data_in[2*PW +: PW];
    end
    check("bp_busy", 64'(bus.busy), 64'd1);
    check("bp_grant", 64'(bus.grant_id), 64'd2);
    check("bp_stall", 64'(bus.stall_err), 64'd0);
    bus.full = 1'b0;
    @(negedge clk);
    #1;
    check("bp_push", 64'(bus.push), 64'd1);
    bus.pndng = '0;

    // Stall error after 16 blocked GRANT cycles, packet still delivered.
    @(negedge clk);
    bus.full = 1'b1;
    bus.pndng = 4'b1000;
    expect_pkt(3);
    repeat (16) @(negedge clk);
    #1;
    check("stall_pre", 64'(bus.stall_err), 64'd0);
    @(negedge clk);
    #1;
    check("stall_set", 64'(bus.stall_err), 64'd1);
    check("stall_nopush", 64'(bus.push), 64'd0);
    repeat (3) @(negedge clk);
    bus.full = 1'b0;
    wait_push();
    bus.pndng = '0;
    @(negedge clk);
    #1;
    check("stall_sticky", 64'(bus.stall_err), 64'd1);
    check("stall_idle", 64'(bus.busy), 64'd0);

    // Withdrawn request leaves rr_ptr at 3.
    @(negedge clk);
    bus.full = 1'b1;
    bus.pndng = 4'b0100;
    @(negedge clk);
    #1;
    check("wd_grant", 64'(bus.grant_id), 64'd2);
    bus.pndng = '0;
    @(negedge clk);
    #1;
    check("wd_idle", 64'(bus.busy), 64'd0);
    bus.full = 1'b0;
    @(negedge clk);
    bus.pndng = 4'b1100;
    expect_pkt(2);
    wait_push();
    bus.pndng = '0;
    @(negedge clk);
    bus.pndng = 4'b0101;
    expect_pkt(0);
    wait_push();
    bus.pndng = '0;

    // Asynchronous reset in the middle of XFER.
    @(negedge clk);
    bus.pndng = 4'b0010;
    expect_pkt(1);
    wait_push();
    reset = 1'b1;
    #1;
    check("ar_push", 64'(bus.push), 64'd0);
    check("ar_pop", 64'(bus.pop), 64'd0);
    check("ar_busy", 64'(bus.busy), 64'd0);
    check("ar_cnt", 64'(bus.pkt_cnt), 64'd0);
    check("ar_data", 64'(bus.data_out), 64'd0);
    bus.pndng = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.pndng = 4'b1111;
    expect_pkt(0);
    wait_push();
    bus.pndng = '0;
    @(negedge clk);
    #1;
    check("ar_cnt_after", 64'(bus.pkt_cnt), 64'd1);
    check("sb_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
